// File: rtl/serdes_arb_pkg.sv
// Shared types and helpers for the serdes TX arbiter: FSM state encoding and header word construction.
package serdes_arb_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, BURST} arb_state_t;

  localparam logic [3:0] HDR_MARKER = 4'hA;
  localparam int         HDR_MAX_W  = 64;

  // Marker sits in the top nibble of a data_w-bit word; the ID sits in the low bits.
  function automatic logic [HDR_MAX_W-1:0] build_header(input int data_w, input logic [7:0] id);
    logic [HDR_MAX_W-1:0] hdr;
    hdr = HDR_MAX_W'(id) | (HDR_MAX_W'(HDR_MARKER) << (data_w - 4));
    return hdr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping to the lowest index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0]            w_mask;
  logic [NUM_REQ-1:0]            w_hi;
  logic [ID_W-1:0][NUM_REQ-1:0]  w_pat;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (ID_W'(gi) >= ptr_i);
    end
    // w_pat[b] selects the requesters whose index has bit b set, for one-hot to binary encoding.
    for (genvar bi = 0; bi < ID_W; bi++) begin : g_enc
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pat
        assign w_pat[bi][gi] = ((gi >> bi) & 1) != 0;
      end
      assign id_o[bi] = |(grant_o & w_pat[bi]);
    end
  endgenerate

  assign w_hi  = req_i & w_mask;
  assign any_o = |req_i;

  // x & -x isolates the lowest set bit; fall back to the unmasked vector on wrap.
  always_comb begin
    grant_o = '0;
    if (|w_hi) begin
      grant_o = w_hi & (~w_hi + 1'b1);
    end else begin
      grant_o = req_i & (~req_i + 1'b1);
    end
  end

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Burst-granular round-robin arbiter in front of the serdes TX; each burst is preceded by an ID header.
// Optional statistics counters are enabled with the SERDES_ARB_STATS_EN macro.
module serdes_tx_arbiter
  import serdes_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         ser_data_o,
  output logic                          ser_valid_o,
  input  logic                          ser_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
`ifdef SERDES_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt_o,
  output logic [15:0]                   split_cnt_o
`endif
);

  localparam int              CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_t          r_state, w_state_next;
  logic [NUM_REQ-1:0]  r_grant;
  logic [ID_W-1:0]     r_gnt_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_beat_cnt;

  logic [NUM_REQ-1:0]    w_arb_grant;
  logic [ID_W-1:0]       w_arb_id;
  logic [ID_W-1:0]       w_ptr_next;
  logic                  w_arb_any;
  logic                  w_take;
  logic                  w_gnt_valid;
  logic                  w_gnt_last;
  logic                  w_xfer;
  logic                  w_burst_end;
  logic [DATA_WIDTH-1:0] w_hdr;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid_i),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_arb_grant),
    .id_o    (w_arb_id),
    .any_o   (w_arb_any)
  );

  assign w_take      = (r_state == IDLE) && w_arb_any;
  assign w_ptr_next  = (w_arb_id == ID_W'(NUM_REQ - 1)) ? '0 : w_arb_id + 1'b1;
  assign w_gnt_valid = |(req_valid_i & r_grant);
  assign w_gnt_last  = |(req_last_i & r_grant);
  assign w_gnt_data  = DATA_WIDTH'(req_data_i >> (32'(r_gnt_id) * DATA_WIDTH));
  assign w_hdr       = DATA_WIDTH'(build_header(DATA_WIDTH, 8'(r_gnt_id)));
  assign grant_o     = r_grant;

  always_comb begin
    w_state_next = r_state;
    ser_valid_o  = 1'b0;
    ser_data_o   = '0;
    req_ready_o  = '0;
    busy_o       = 1'b0;
    w_xfer       = 1'b0;
    w_burst_end  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) w_state_next = HEADER;
      end
      HEADER: begin
        busy_o      = 1'b1;
        ser_valid_o = 1'b1;
        ser_data_o  = w_hdr;
        if (ser_ready_i) w_state_next = BURST;
      end
      BURST: begin
        // Pass-through of the granted requester; a valid gap simply holds the grant.
        busy_o      = 1'b1;
        ser_valid_o = w_gnt_valid;
        ser_data_o  = w_gnt_data;
        req_ready_o = r_grant & {NUM_REQ{ser_ready_i}};
        w_xfer      = w_gnt_valid & ser_ready_i;
        w_burst_end = w_xfer & (w_gnt_last | (r_beat_cnt == LAST_BEAT));
        if (w_burst_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_grant  <= w_arb_grant;
            r_gnt_id <= w_arb_id;
            r_rr_ptr <= w_ptr_next;
          end
        end
        HEADER: begin
          if (ser_ready_i) r_beat_cnt <= '0;
        end
        BURST: begin
          if (w_burst_end) begin
            r_grant    <= '0;
            r_beat_cnt <= '0;
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

`ifdef SERDES_ARB_STATS_EN
  logic        w_split;
  logic [15:0] r_split_cnt;

  // A burst ending without its own last marker was cut at MAX_BURST.
  assign w_split     = w_burst_end & ~w_gnt_last;
  assign split_cnt_o = r_split_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_split_cnt <= '0;
    end else if (w_split && (r_split_cnt != 16'hFFFF)) begin
      r_split_cnt <= r_split_cnt + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
      logic [15:0] r_cnt;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (w_take && w_arb_grant[gi] && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign grant_cnt_o[gi*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
